branch_target_lut: RTL
======================

# branch_target_lut

Writable, parametrised branch-target lookup table for the fetch stage. A few-bit pointer from the branch instruction selects an entry. The entry yields either an absolute PC target or a signed offset added to the current PC. After reset the table self-initialises to identity defaults, then serves one registered lookup per cycle. It also accepts one runtime write per cycle from the program loader.

## Interface
- ADDR_W, 4, pointer width.
- TGT_W, 8, PC/target width.
- DEPTH, 8, implemented entries; 1 ≤ DEPTH ≤ 2**ADDR_W.
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- rd_en  in  1  lookup request.
- rd_addr  in  ADDR_W  entry pointer.
- pc  in  TGT_W  current PC, sampled with rd_en.
- target  out  TGT_W  registered lookup result.
- target_valid  out  1  target updated this cycle.
- wr_en  in  1  entry write request.
- wr_addr  in  ADDR_W  entry to write.
- wr_data  in  TGT_W  absolute target or two's-complement offset.
- wr_rel  in  1  1 = PC-relative entry, 0 = absolute entry.
- wr_err  out  1  one-cycle pulse: write rejected.
- init_busy  out  1  table initialising; lookups and writes are not served.

## Operation
- Storage: DEPTH entries of {rel, value[TGT_W-1:0]}.
- FSM states:
  - INIT: while in INIT, init_busy = 1. Each cycle writes entry idx with {0, idx zero-extended} and increments idx. After writing idx = DEPTH-1, the next state is RUN.
  - RUN: init_busy = 0. Stays in RUN until Reset.
- Lookup in RUN:
  - rd_en = 1 with rd_addr < DEPTH: target = value if rel = 0, else (pc + value) mod 2**TGT_W. The value is treated as signed, and wrap-around is silent.
  - rd_en = 1 with rd_addr ≥ DEPTH: target = 0, target_valid = 1.
- Lookup rejected:
  - rd_en = 1 in INIT: target_valid = 0 next cycle; target holds.
  - rd_en = 0: target_valid = 0; target holds its last value.
- Write in RUN:
  - wr_en = 1 with wr_addr < DEPTH: the entry takes {wr_rel, wr_data} at the edge.
- Write rejected, no storage change, wr_err = 1 for the next cycle:
  - wr_en = 1 in INIT;
  - wr_en = 1 with wr_addr ≥ DEPTH.
- Simultaneous read and write of the same address in RUN: write-first. The lookup uses the incoming {wr_rel, wr_data} (forwarded) and the table is updated in the same edge. Different addresses are independent.
- Reset, at any time including mid-INIT or mid-lookup:
  - state = INIT, idx = 0;
  - target = 0, target_valid = 0, wr_err = 0, init_busy = 1;
  - entry contents are don't-care until re-initialised.

## Timing
- Outputs immediately after Reset asserts: target = 0, target_valid = 0, wr_err = 0, init_busy = 1.
- Initialisation takes exactly DEPTH cycles. init_busy falls on the DEPTH-th rising edge after Reset deasserts.
- Earliest accepted request is in the cycle after init_busy reads 0.
- Lookup latency is 1 cycle: request at edge N gives target/target_valid valid after edge N+1.
- Throughput is one lookup and one write per cycle.
- A write at edge N is visible to a lookup at edge N (forwarding) and to all later lookups.
- wr_err is asserted for exactly one cycle per rejected write.

## Test plan
All scenarios use ADDR_W = 4, TGT_W = 8, DEPTH = 8.
- Init: release Reset, count cycles -> init_busy high for exactly 8 cycles. Then read addr 5 -> target = 5, target_valid = 1 one cycle later. A read issued during INIT -> target_valid = 0.
- Absolute and relative entries:
  - write addr 2 = 30 with wr_rel = 0, then read -> 30;
  - write addr 3 = 0xFE with wr_rel = 1, read with pc = 0x40 -> 0x3E.
- Wrap-around: write addr 1 = 0x10 relative, read with pc = 0xF8 -> target = 0x08.
- Read/write collision: in one cycle, write addr 4 = 94 absolute and read addr 4 -> target = 94 next cycle. A later read of addr 4 -> 94.
- Out of range and rejection:
  - read addr 9 -> target = 0, target_valid = 1;
  - write addr 12 -> wr_err pulses for 1 cycle, then read addr 4 still returns 94;
  - write during INIT -> wr_err pulses.
- Reset mid-operation: after the writes above, assert Reset asynchronously mid-cycle -> outputs clear with no clock edge. After 8 init cycles, read addr 2 -> 2 (default restored).

Source files
------------

// File: rtl/branch_target_lut_if.sv
// Lookup/write bus between the fetch stage and the branch-target table.
interface branch_target_lut_if #(
  parameter int ADDR_W = 4,
  parameter int TGT_W  = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [TGT_W-1:0]  pc;
  logic [TGT_W-1:0]  target;
  logic              target_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [TGT_W-1:0]  wr_data;
  logic              wr_rel;
  logic              wr_err;
  logic              init_busy;

  modport master (
    output rd_en, rd_addr, pc, wr_en, wr_addr, wr_data, wr_rel,
    input  target, target_valid, wr_err, init_busy
  );

  modport slave (
    input  rd_en, rd_addr, pc, wr_en, wr_addr, wr_data, wr_rel,
    output target, target_valid, wr_err, init_busy
  );
endinterface

// File: rtl/branch_target_lut.sv
// Branch-target lookup table: self-initialises to identity entries after
// reset, then serves one registered lookup and one write per cycle.
// Entries hold either an absolute target or a signed PC-relative offset.
module branch_target_lut #(
  parameter int ADDR_W = 4,
  parameter int TGT_W  = 8,
  parameter int DEPTH  = 8
) (
  input logic               clk,
  input logic               rst,
  branch_target_lut_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              init_we;

  logic [TGT_W:0]    mem [0:DEPTH-1];

  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_ok;
  logic              wr_ok;
  logic              fwd;
  logic [TGT_W:0]    entry;
  logic [TGT_W-1:0]  lookup_val;

  // State register and init index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (init_we) idx <= idx + 1'b1;
    end
  end

  // Next-state logic, init write strobe and busy flag.
  always_comb begin
    state_nxt     = state;
    init_we       = 1'b0;
    bus.init_busy = 1'b0;
    case (state)
      INIT: begin
        init_we       = 1'b1;
        bus.init_busy = 1'b1;
        if (idx == LAST) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Lookup datapath; a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
    wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
    rd_ok       = (state == RUN) && bus.rd_en;
    wr_ok       = (state == RUN) && bus.wr_en && wr_in_range;
    fwd         = wr_ok && (bus.wr_addr == bus.rd_addr);
    entry       = fwd ? {bus.wr_rel, bus.wr_data} : mem[bus.rd_addr[IDX_W-1:0]];
    lookup_val  = entry[TGT_W] ? (bus.pc + entry[TGT_W-1:0]) : entry[TGT_W-1:0];
  end

  // Table storage: identity fill during INIT, loader writes during RUN.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[idx[IDX_W-1:0]] <= {1'b0, TGT_W'(idx)};
    end else if (wr_ok) begin
      mem[bus.wr_addr[IDX_W-1:0]] <= {bus.wr_rel, bus.wr_data};
    end
  end

  // Registered lookup result and write-reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.target       <= '0;
      bus.target_valid <= 1'b0;
      bus.wr_err       <= 1'b0;
    end else begin
      bus.target_valid <= rd_ok;
      if (rd_ok) bus.target <= rd_in_range ? lookup_val : '0;
      bus.wr_err <= bus.wr_en && ((state == INIT) || !wr_in_range);
    end
  end

endmodule
